rtclock_pps_servo: RTL and testbench

//  Closed-loop controller that disciplines the rtclock counter to an external 1PPS.
//  - Measures the PPS period in clk cycles.
//  - Steps the clock (seconds/ns load) on large phase error.
//  - Otherwise trims the per-cycle ns increment (delta) proportionally.
//  - Sits between the PPS input conditioner and the rtclock core.
//  - Its outputs feed the sec_config load path and corrected_delta_pps.

---
 rtl/rtclock_pps_servo.sv | 215 +++++++++++++++++++++
 tb/tb_rtclock_pps_servo.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtclock_pps_servo.sv
// PPS servo for the rtclock core: measures the PPS period, steps time on large
// phase error and otherwise trims the ns/cycle increment proportionally.
//
// state        | meaning
// DISABLED     | servo off, delta held at nominal
// WAIT_FIRST   | enabled, waiting for the first PPS edge
// STEP         | one cycle, load_valid asserted with load_sec/load_ns
// TRACK        | PPS present, proportional trimming of delta
// HOLDOVER     | PPS lost, delta frozen until the next edge
module rtclock_pps_servo #(
  parameter logic [31:0] DELTA_NOMINAL = 32'h0400_0000,
  parameter logic [31:0] DELTA_LIMIT   = 32'h0001_0000,
  parameter int          GAIN_SHIFT    = 4,
  parameter int          STEP_THRESH   = 1000,
  parameter logic [31:0] TIMEOUT_CYC   = 32'd275000000,
  parameter int          LOCK_COUNT    = 4,
  parameter logic [29:0] LOAD_NS_COMP  = 30'd8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        pps_in,
  input  logic [31:0] time_sec_in,
  input  logic [29:0] time_ns_in,
  output logic        load_valid,
  output logic [31:0] load_sec,
  output logic [29:0] load_ns,
  output logic [31:0] delta_out,
  output logic        delta_valid,
  output logic [31:0] period_cycles,
  output logic [2:0]  state_out,
  output logic        locked,
  output logic [15:0] pps_missed
);

  typedef enum logic [2:0] {
    ST_DISABLED   = 3'd0,
    ST_WAIT_FIRST = 3'd1,
    ST_STEP       = 3'd2,
    ST_TRACK      = 3'd3,
    ST_HOLDOVER   = 3'd4
  } state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [31:0] D_LO = DELTA_NOMINAL - DELTA_LIMIT;
  localparam logic [31:0] D_HI = DELTA_NOMINAL + DELTA_LIMIT;
  localparam logic signed [33:0] D_LO_S = $signed({2'b00, D_LO});
  localparam logic signed [33:0] D_HI_S = $signed({2'b00, D_HI});

  state_t state_q, state_nx;

  logic               pps_q;
  logic [31:0]        cnt_q;
  logic [31:0]        sec_cap;
  logic [29:0]        ns_cap;
  logic               eval_q;
  logic               upd_q;
  logic signed [31:0] adj_q;
  logic [GW-1:0]      good_q;
  logic [31:0]        delta_q;
  logic               delta_valid_q;
  logic [31:0]        period_q;
  logic [15:0]        missed_q;
  logic [31:0]        load_sec_q;
  logic [29:0]        load_ns_q;

  logic               edge_det;
  logic               ns_hi;
  logic signed [31:0] err;
  logic [31:0]        err_mag;
  logic               big_err;
  logic               tracking;
  logic               timeout;
  logic               step_go;
  logic               trim_go;
  logic               timeout_go;
  logic signed [33:0] delta_sum;
  logic [31:0]        delta_new;

  assign edge_det = pps_in & ~pps_q;
  assign ns_hi    = (ns_cap >= 30'd500000000);
  // Captured ns folded into a signed offset from the nearest second boundary.
  assign err      = ns_hi ? ($signed({2'b00, ns_cap}) - 32'sd1000000000)
                          : $signed({2'b00, ns_cap});
  assign err_mag  = err[31] ? 32'(-err) : 32'(err);
  assign big_err  = (err_mag > 32'(STEP_THRESH));
  assign tracking = (state_q == ST_TRACK) || (state_q == ST_HOLDOVER);
  assign timeout  = (state_q == ST_TRACK) && (cnt_q == TIMEOUT_CYC);

  assign delta_sum = $signed({2'b00, delta_q}) - $signed({{2{adj_q[31]}}, adj_q});

  always_comb begin
    delta_new = delta_sum[31:0];
    if (delta_sum < D_LO_S) begin
      delta_new = D_LO;
    end else if (delta_sum > D_HI_S) begin
      delta_new = D_HI;
    end
  end

  always_comb begin
    state_nx   = state_q;
    step_go    = 1'b0;
    trim_go    = 1'b0;
    timeout_go = 1'b0;
    if (!enable) begin
      state_nx = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED:   state_nx = ST_WAIT_FIRST;
        ST_WAIT_FIRST: begin
          if (eval_q) begin
            state_nx = ST_STEP;
            step_go  = 1'b1;
          end
        end
        ST_STEP:       state_nx = ST_TRACK;
        ST_TRACK, ST_HOLDOVER: begin
          if (eval_q) begin
            if (big_err) begin
              state_nx = ST_STEP;
              step_go  = 1'b1;
            end else begin
              state_nx = ST_TRACK;
              trim_go  = 1'b1;
            end
          end else if (timeout) begin
            state_nx   = ST_HOLDOVER;
            timeout_go = 1'b1;
          end
        end
        default:       state_nx = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_DISABLED;
      pps_q         <= 1'b0;
      cnt_q         <= '0;
      sec_cap       <= '0;
      ns_cap        <= '0;
      eval_q        <= 1'b0;
      upd_q         <= 1'b0;
      adj_q         <= '0;
      good_q        <= '0;
      delta_q       <= DELTA_NOMINAL;
      delta_valid_q <= 1'b0;
      period_q      <= '0;
      missed_q      <= '0;
      load_sec_q    <= '0;
      load_ns_q     <= '0;
    end else begin
      state_q <= state_nx;
      pps_q   <= pps_in;

      if (edge_det) begin
        cnt_q   <= '0;
        sec_cap <= time_sec_in;
        ns_cap  <= time_ns_in;
        if (tracking) begin
          period_q <= (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        end
      end else if (cnt_q != 32'hFFFF_FFFF) begin
        cnt_q <= cnt_q + 32'd1;
      end

      // Edges seen while a step is being issued only restart the period count.
      eval_q <= enable && edge_det && !eval_q &&
                (state_q == ST_WAIT_FIRST || tracking);

      upd_q <= trim_go;
      if (trim_go) begin
        adj_q <= err >>> GAIN_SHIFT;
      end

      delta_valid_q <= 1'b0;
      if (!enable) begin
        delta_q       <= DELTA_NOMINAL;
        delta_valid_q <= (state_q != ST_DISABLED);
      end else if (upd_q) begin
        delta_q       <= delta_new;
        delta_valid_q <= 1'b1;
      end

      if (step_go || timeout_go || !enable) begin
        good_q <= '0;
      end else if (trim_go && good_q != GOOD_MAX) begin
        good_q <= good_q + 1'b1;
      end

      if (timeout_go && missed_q != 16'hFFFF) begin
        missed_q <= missed_q + 16'd1;
      end

      if (step_go) begin
        load_sec_q <= sec_cap + {31'd0, ns_hi};
        load_ns_q  <= LOAD_NS_COMP;
      end
    end
  end

  assign load_valid    = (state_q == ST_STEP);
  assign load_sec      = load_sec_q;
  assign load_ns       = load_ns_q;
  assign delta_out     = delta_q;
  assign delta_valid   = delta_valid_q;
  assign period_cycles = period_q;
  assign state_out     = state_q;
  assign locked        = (state_q == ST_TRACK) && (good_q == GOOD_MAX);
  assign pps_missed    = missed_q;

endmodule

// File: tb/tb_rtclock_pps_servo.sv
// Bench for rtclock_pps_servo: directed vector table, hand sequences for the
// multi-cycle corners, and randomized PPS edges checked against a reference model.
module tb_rtclock_pps_servo;

  localparam int     TIMEOUT = 300;
  localparam int     THRESH  = 200000;
  localparam int     GAIN    = 4;
  localparam int     LOCKN   = 4;
  localparam longint NOM     = 64'h0400_0000;
  localparam longint LIM     = 64'h0001_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        pps_in = 1'b0;
  logic [31:0] time_sec_in = '0;
  logic [29:0] time_ns_in = '0;
  logic        load_valid;
  logic [31:0] load_sec;
  logic [29:0] load_ns;
  logic [31:0] delta_out;
  logic        delta_valid;
  logic [31:0] period_cycles;
  logic [2:0]  state_out;
  logic        locked;
  logic [15:0] pps_missed;

  rtclock_pps_servo #(
    .STEP_THRESH (THRESH),
    .TIMEOUT_CYC (32'(TIMEOUT))
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .pps_in        (pps_in),
    .time_sec_in   (time_sec_in),
    .time_ns_in    (time_ns_in),
    .load_valid    (load_valid),
    .load_sec      (load_sec),
    .load_ns       (load_ns),
    .delta_out     (delta_out),
    .delta_valid   (delta_valid),
    .period_cycles (period_cycles),
    .state_out     (state_out),
    .locked        (locked),
    .pps_missed    (pps_missed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] period;
    logic        lv1;
    logic [2:0]  st1;
    logic [31:0] lsec;
    logic [29:0] lns;
    logic        lock1;
    logic        dv1;
    logic [31:0] delta2;
    logic        dv2;
    logic [2:0]  st2;
    logic        lv2;
  } obs_t;

  typedef struct {
    logic [31:0] sec;
    logic [29:0] ns;
    logic        step;
    logic [31:0] lsec;
    logic [31:0] delta;
    logic        lock;
  } vec_t;

  vec_t tbl[11];

  // reference model: servo state, delta, good-edge count, edge timestamps
  int          m_state = 0;
  longint      m_delta = NOM;
  int          m_good = 0;
  int          last_e = 0;
  logic [31:0] m_period = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_reset_vals();
    chk("rst_state", state_out, 3'd0);
    chk("rst_delta", delta_out, NOM);
    chk("rst_period", period_cycles, 0);
    chk("rst_missed", pps_missed, 0);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_delta_valid", delta_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_load_sec", load_sec, 0);
    chk("rst_load_ns", load_ns, 0);
  endtask

  task automatic do_edge(input logic [31:0] sec, input logic [29:0] ns, input logic hold,
                         output obs_t o, output int ce);
    pps_in = 1'b1;
    time_sec_in = sec;
    time_ns_in = ns;
    tick();
    ce = cyc;
    o.period = period_cycles;
    pps_in = hold;
    time_sec_in = $urandom;
    time_ns_in = 30'($urandom_range(0, 999999999));
    tick();
    o.lv1 = load_valid;
    o.st1 = state_out;
    o.lsec = load_sec;
    o.lns = load_ns;
    o.lock1 = locked;
    o.dv1 = delta_valid;
    tick();
    o.delta2 = delta_out;
    o.dv2 = delta_valid;
    o.st2 = state_out;
    o.lv2 = load_valid;
  endtask

  task automatic model_check(input logic [31:0] sec, input logic [29:0] ns,
                             input obs_t o, input int ce);
    int          err;
    bit          big;
    longint      d;
    logic [31:0] exp_sec;
    err = (ns < 30'd500000000) ? int'(ns) : int'(ns) - 1000000000;
    if (m_state == 3 || m_state == 4) m_period = 32'(ce - last_e);
    last_e = ce;
    chk("m_period", o.period, m_period);
    big = (m_state == 1) || (err > THRESH) || (err < -THRESH);
    chk("m_dv_e1", o.dv1, 0);
    chk("m_lv_e2", o.lv2, 0);
    chk("m_state_e2", o.st2, 3);
    if (big) begin
      m_good = 0;
      exp_sec = sec + ((ns >= 30'd500000000) ? 32'd1 : 32'd0);
      chk("m_load_valid", o.lv1, 1);
      chk("m_state_e1", o.st1, 2);
      chk("m_load_sec", o.lsec, exp_sec);
      chk("m_load_ns", o.lns, 8);
      chk("m_locked", o.lock1, 0);
      chk("m_delta_hold", o.delta2, m_delta);
      chk("m_dv_step", o.dv2, 0);
    end else begin
      if (m_good < LOCKN) m_good++;
      d = m_delta - longint'(err >>> GAIN);
      if (d < NOM - LIM) d = NOM - LIM;
      if (d > NOM + LIM) d = NOM + LIM;
      m_delta = d;
      chk("m_load_valid", o.lv1, 0);
      chk("m_state_e1", o.st1, 3);
      chk("m_locked", o.lock1, (m_good == LOCKN) ? 1 : 0);
      chk("m_delta", o.delta2, m_delta);
      chk("m_dv_trim", o.dv2, 1);
    end
    m_state = 3;
  endtask

  task automatic model_edge(input logic [31:0] sec, input logic [29:0] ns, input logic hold);
    obs_t o;
    int   ce;
    do_edge(sec, ns, hold, o, ce);
    model_check(sec, ns, o, ce);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    obs_t o;
    int   ce;
    bit   seen;
    int   pulses;
    logic [29:0] ns;

    tbl[0]  = '{32'd10, 30'd123,       1'b1, 32'd10, 32'h0400_0000, 1'b0};
    tbl[1]  = '{32'd11, 30'd999999840, 1'b0, 32'd0,  32'h0400_000A, 1'b0};
    tbl[2]  = '{32'd12, 30'd32,        1'b0, 32'd0,  32'h0400_0008, 1'b0};
    tbl[3]  = '{32'd13, 30'd999999999, 1'b0, 32'd0,  32'h0400_0009, 1'b0};
    tbl[4]  = '{32'd14, 30'd15,        1'b0, 32'd0,  32'h0400_0009, 1'b1};
    tbl[5]  = '{32'd20, 30'd600000000, 1'b1, 32'd21, 32'h0400_0009, 1'b0};
    tbl[6]  = '{32'd30, 30'd500000000, 1'b1, 32'd31, 32'h0400_0009, 1'b0};
    tbl[7]  = '{32'd40, 30'd1600,      1'b0, 32'd0,  32'h03FF_FFA5, 1'b0};
    tbl[8]  = '{32'd50, 30'd200000,    1'b0, 32'd0,  32'h03FF_CED1, 1'b0};
    tbl[9]  = '{32'd60, 30'd200001,    1'b1, 32'd60, 32'h03FF_CED1, 1'b0};
    tbl[10] = '{32'd70, 30'd999800000, 1'b0, 32'd0,  32'h03FF_FFA5, 1'b0};

    idle(3);
    chk_reset_vals();
    resetn = 1'b1;
    idle(3);
    chk("idle_disabled", state_out, 0);
    chk("idle_no_dv", delta_valid, 0);
    enable = 1'b1;
    tick();
    chk("enable_wait_first", state_out, 1);
    m_state = 1;
    idle(5);

    for (int i = 0; i < 11; i++) begin
      do_edge(tbl[i].sec, tbl[i].ns, 1'b0, o, ce);
      chk("tbl_load_valid", o.lv1, tbl[i].step);
      if (tbl[i].step) chk("tbl_load_sec", o.lsec, tbl[i].lsec);
      chk("tbl_delta", o.delta2, tbl[i].delta);
      chk("tbl_locked", o.lock1, tbl[i].lock);
      model_check(tbl[i].sec, tbl[i].ns, o, ce);
      idle(20);
    end

    // reach lock, then starve the PPS into holdover
    for (int i = 0; i < 3; i++) begin
      model_edge($urandom, 30'($urandom_range(0, THRESH)), 1'b0);
      idle(15);
    end
    chk("lock_reached", locked, 1);
    seen = 1'b0;
    for (int k = 0; k < TIMEOUT + 50; k++) begin
      tick();
      if (state_out == 3'd4) begin
        seen = 1'b1;
        break;
      end
    end
    chk("holdover_seen", seen, 1);
    chk("holdover_cycle", cyc - last_e, TIMEOUT + 1);
    chk("holdover_locked", locked, 0);
    chk("holdover_missed", pps_missed, 1);
    chk("holdover_delta", delta_out, m_delta);
    m_state = 4;
    m_good = 0;
    idle(7);
    do_edge(32'd100, 30'd600000000, 1'b0, o, ce);
    chk("hold_step_sec", o.lsec, 101);
    chk("hold_step_period", o.period, ce - last_e);
    model_check(32'd100, 30'd600000000, o, ce);
    idle(10);

    // clamp at both limits
    for (int i = 0; i < 14; i++) begin
      model_edge(32'd200, 30'd100000, 1'b0);
      idle(10);
    end
    chk("clamp_low", delta_out, 32'h03FF_0000);
    for (int i = 0; i < 24; i++) begin
      model_edge(32'd300, 30'd999900000, 1'b0);
      idle(10);
    end
    chk("clamp_high", delta_out, 32'h0401_0000);

    // pps held high yields one edge only
    model_edge(32'd400, 30'd40, 1'b1);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (load_valid || delta_valid) pulses++;
    end
    chk("held_high_pulses", pulses, 0);
    pps_in = 1'b0;
    idle(5);

    // edge during STEP is ignored but restarts the period count
    pps_in = 1'b1;
    time_sec_in = 32'd500;
    time_ns_in = 30'd700000000;
    tick();
    m_period = 32'(cyc - last_e);
    last_e = cyc;
    chk("istep_period", period_cycles, m_period);
    pps_in = 1'b0;
    tick();
    chk("istep_load_valid", load_valid, 1);
    chk("istep_load_sec", load_sec, 501);
    pps_in = 1'b1;
    tick();
    last_e = cyc;
    pps_in = 1'b0;
    chk("istep_state_e2", state_out, 3);
    tick();
    chk("istep_no_load", load_valid, 0);
    chk("istep_state_e3", state_out, 3);
    tick();
    chk("istep_no_dv", delta_valid, 0);
    m_state = 3;
    m_good = 0;
    idle(12);
    model_edge(32'd501, 30'd77, 1'b0);
    idle(10);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ns = 30'($urandom_range(0, THRESH));
        1: ns = 30'(1000000000 - $urandom_range(1, THRESH));
        2: ns = 30'($urandom_range(0, 999999999));
        default: begin
          case ($urandom_range(0, 5))
            0: ns = 30'(THRESH);
            1: ns = 30'(THRESH + 1);
            2: ns = 30'(1000000000 - THRESH);
            3: ns = 30'(1000000000 - THRESH - 1);
            4: ns = 30'd499999999;
            default: ns = 30'd500000000;
          endcase
        end
      endcase
      model_edge($urandom, ns, 1'b0);
      idle($urandom_range(0, 60));
    end

    // enable dropped mid-period
    idle(10);
    enable = 1'b0;
    tick();
    chk("dis_state", state_out, 0);
    chk("dis_delta", delta_out, NOM);
    chk("dis_dv_pulse", delta_valid, 1);
    tick();
    chk("dis_dv_once", delta_valid, 0);
    chk("dis_no_load", load_valid, 0);
    m_state = 0;
    m_delta = NOM;
    m_good = 0;
    enable = 1'b1;
    tick();
    chk("reen_state", state_out, 1);
    m_state = 1;
    idle(4);
    model_edge(32'd900, 30'd5, 1'b0);
    idle(10);

    // enable dropped on the edge cycle aborts the pending trim
    pps_in = 1'b1;
    time_sec_in = 32'd901;
    time_ns_in = 30'd999999000;
    tick();
    m_period = 32'(cyc - last_e);
    last_e = cyc;
    pps_in = 1'b0;
    enable = 1'b0;
    tick();
    chk("abort_trim_state", state_out, 0);
    chk("abort_trim_dv", delta_valid, 1);
    tick();
    chk("abort_trim_delta", delta_out, NOM);
    chk("abort_trim_dv2", delta_valid, 0);
    enable = 1'b1;
    tick();
    idle(3);

    // enable dropped on the edge cycle aborts the pending step
    pps_in = 1'b1;
    time_sec_in = 32'd902;
    time_ns_in = 30'd123456;
    tick();
    last_e = cyc;
    pps_in = 1'b0;
    enable = 1'b0;
    tick();
    chk("abort_step_load", load_valid, 0);
    chk("abort_step_state", state_out, 0);
    tick();
    chk("abort_step_load2", load_valid, 0);
    m_state = 0;
    m_delta = NOM;

    // reset mid-operation
    enable = 1'b1;
    tick();
    m_state = 1;
    idle(3);
    model_edge(32'd950, 30'd10, 1'b0);
    idle(10);
    model_edge(32'd951, 30'd999990000, 1'b0);
    idle(3);
    resetn = 1'b0;
    tick();
    chk_reset_vals();
    resetn = 1'b1;
    enable = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
